ram_loader: RTL

//  Byte-stream program loader that sits directly upstream of the 16x8 RAM.

---
 rtl/ram_loader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
// Byte-stream program loader for the 16x8 RAM: frame = sync byte, NUM_WORDS data bytes, checksum.
// Each data byte is written through the RAM programming port in a dedicated one-cycle WRITE state.
module ram_loader #(
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              prog_mode,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] program_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] cks_q, cks_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              prog_q, prog_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              xfer_s;

    // abort wins over any handshake and over a write already in progress
    assign xfer_s       = in_valid & rdy_q & ~abort;
    assign in_ready     = rdy_q & ~abort;
    assign prog_mode    = prog_q & ~abort;
    assign prog_addr    = addr_q;
    assign program_data = data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

    // Next-state and next-output computation for the loader FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cks_d   = cks_q;
        addr_d  = addr_q;
        data_d  = data_q;
        prog_d  = 1'b0;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = {ADDR_W{1'b0}};
            rdy_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_d = S_SYNC;
                        cnt_d   = {ADDR_W{1'b0}};
                        cks_d   = {DATA_W{1'b0}};
                        rdy_d   = 1'b1;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_SYNC: begin
                    if (xfer_s && (in_data == SYNC_BYTE)) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_SYNC;
                    end
                end
                S_DATA: begin
                    if (xfer_s) begin
                        state_d = S_WRITE;
                        addr_d  = cnt_q;
                        data_d  = in_data;
                        cks_d   = cks_q + in_data;
                        prog_d  = 1'b1;
                        rdy_d   = 1'b0;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_WRITE: begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    rdy_d = 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_CHECK: begin
                    if (xfer_s) begin
                        rdy_d  = 1'b0;
                        busy_d = 1'b0;
                        if (in_data == cks_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
                    end else begin
                        state_d = S_CHECK;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    rdy_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and registered-output flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {ADDR_W{1'b0}};
            cks_q   <= {DATA_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            data_q  <= {DATA_W{1'b0}};
            prog_q  <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cks_q   <= cks_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            prog_q  <= prog_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule
